// File: rtl/reg_status_file.sv
// Purpose: architectural register values plus per-register pending ROB producer tags.
// Latency: reads are combinational, with a same-cycle commit bypass. Rename and commit reach state at the next posedge.
// Backpressure: there is no handshake; rdy_in=0 freezes all state while reads stay live.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   rename_*     : dispatch records a new producer tag for a destination register
//   rs1_*, rs2_* : source index in; value or pending tag out (tag 0 = value ready)
//   cdb_*        : ROB commit broadcast retiring a value into architectural state
//   predict_fail : mispredict flush; drops all pending tags
module reg_status_file #(
  parameter int TAG_W = 4,
  parameter int NREG  = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rename_valid,
  input  logic [4:0]       rename_rd_idx,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [31:0]      rs1_val,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [31:0]      rs2_val,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [4:0]       cdb_rd_idx,
  input  logic [31:0]      cdb_val,
  input  logic             predict_fail
);

  logic [31:0]      val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];

  logic commit_en;
  logic rename_en;
  logic commit_clr;

  // x0 is never written, so its entries stay at their reset value of zero.
  assign commit_en  = rdy_in && cdb_active && (cdb_rd_idx != 5'd0);
  assign rename_en  = rdy_in && rename_valid && (rename_rd_idx != 5'd0) && !predict_fail;
  // The tag clears only when the committing inst is still the newest producer.
  // A mismatch means a younger rename is pending, so its tag must survive.
  assign commit_clr = commit_en && (tag_q[cdb_rd_idx] == cdb_tag);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      // In-order commit keeps architectural values correct even when the tag is stale.
      if (commit_en) begin
        val_q[cdb_rd_idx] <= cdb_val;
      end
      if (commit_clr) begin
        tag_q[cdb_rd_idx] <= '0;
      end
      if (predict_fail) begin
        for (int i = 0; i < NREG; i++) begin
          tag_q[i] <= '0;
        end
      end else if (rename_en) begin
        // Placed after the commit clear so that a same-cycle rename wins the tag.
        tag_q[rename_rd_idx] <= rename_tag;
      end
    end
  end

  // A commit whose tag matches the pending producer is forwarded in the same cycle.
  // Reads never observe a same-cycle rename.
  always_comb begin
    rs1_val = val_q[rs1_idx];
    rs1_tag = tag_q[rs1_idx];
    if (rs1_idx == 5'd0) begin
      rs1_val = '0;
      rs1_tag = '0;
    end else if (cdb_active && (cdb_rd_idx == rs1_idx) &&
                 (tag_q[rs1_idx] != '0) && (cdb_tag == tag_q[rs1_idx])) begin
      rs1_val = cdb_val;
      rs1_tag = '0;
    end
  end

  always_comb begin
    rs2_val = val_q[rs2_idx];
    rs2_tag = tag_q[rs2_idx];
    if (rs2_idx == 5'd0) begin
      rs2_val = '0;
      rs2_tag = '0;
    end else if (cdb_active && (cdb_rd_idx == rs2_idx) &&
                 (tag_q[rs2_idx] != '0) && (cdb_tag == tag_q[rs2_idx])) begin
      rs2_val = cdb_val;
      rs2_tag = '0;
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Purpose: randomized and directed checking of reg_status_file against a register-level model.
// Latency: outputs are sampled mid-cycle; the model commits its update at each posedge.
// Backpressure: rdy_in is toggled randomly to exercise the hold behaviour.
module tb_reg_status_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        rename_valid;
  logic [4:0]  rename_rd_idx;
  logic [3:0]  rename_tag;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [4:0]  cdb_rd_idx;
  logic [31:0] cdb_val;
  logic        predict_fail;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];

  reg_status_file #(.TAG_W(4), .NREG(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rename_valid(rename_valid), .rename_rd_idx(rename_rd_idx), .rename_tag(rename_tag),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs1_tag(rs1_tag), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_rd_idx(cdb_rd_idx), .cdb_val(cdb_val),
    .predict_fail(predict_fail)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Read rule: x0 reads as zero. A commit matching a pending producer forwards its value.
  function automatic void exp_read(input logic [4:0] idx, output logic [31:0] v, output logic [3:0] t);
    v = m_val[idx];
    t = m_tag[idx];
    if (idx == 0) begin
      v = 0;
      t = 0;
    end else if (cdb_active && cdb_rd_idx == idx && m_tag[idx] != 0 && cdb_tag == m_tag[idx]) begin
      v = cdb_val;
      t = 0;
    end
  endfunction

  task automatic model_step();
    logic [3:0] nt [32];
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0;
        m_tag[i] = 0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < 32; i++) nt[i] = m_tag[i];
      if (cdb_active && cdb_rd_idx != 0) begin
        m_val[cdb_rd_idx] = cdb_val;
        if (m_tag[cdb_rd_idx] == cdb_tag) nt[cdb_rd_idx] = 0;
      end
      if (predict_fail) begin
        for (int i = 0; i < 32; i++) nt[i] = 0;
      end else if (rename_valid && rename_rd_idx != 0) begin
        nt[rename_rd_idx] = rename_tag;
      end
      for (int i = 0; i < 32; i++) m_tag[i] = nt[i];
    end
  endtask

  // Moves to mid-cycle and compares both read ports against the model.
  task automatic eval();
    logic [31:0] v;
    logic [3:0]  t;
    #4;
    exp_read(rs1_idx, v, t);
    chk("rs1_val", rs1_val, v);
    chk("rs1_tag", {28'd0, rs1_tag}, {28'd0, t});
    exp_read(rs2_idx, v, t);
    chk("rs2_val", rs2_val, v);
    chk("rs2_tag", {28'd0, rs2_tag}, {28'd0, t});
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; rename_valid = 0; rename_rd_idx = 0; rename_tag = 0;
    cdb_active = 0; cdb_tag = 0; cdb_rd_idx = 0; cdb_val = 0; predict_fail = 0;
  endtask

  initial begin
    idle();
    rst_in = 1;
    rs1_idx = 5; rs2_idx = 0;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 'x;
      m_tag[i] = 'x;
    end
    @(posedge clk_in); model_step(); #1;
    @(posedge clk_in); model_step(); #1;
    idle();

    // Reset state.
    eval();
    chk("rst_rs1_val", rs1_val, 0);
    chk("rst_rs1_tag", {28'd0, rs1_tag}, 0);
    chk("rst_rs2_val", rs2_val, 0);
    chk("rst_rs2_tag", {28'd0, rs2_tag}, 0);
    tick();

    // Rename, pending read, bypass on commit, then the committed value read from state.
    rename_valid = 1; rename_rd_idx = 3; rename_tag = 2; rs1_idx = 3;
    eval(); tick(); idle();
    eval(); chk("s2_pending_tag", {28'd0, rs1_tag}, 2); tick();
    cdb_active = 1; cdb_tag = 2; cdb_rd_idx = 3; cdb_val = 32'hDEAD;
    eval();
    chk("s2_bypass_val", rs1_val, 32'hDEAD);
    chk("s2_bypass_tag", {28'd0, rs1_tag}, 0);
    tick(); idle();
    eval();
    chk("s2_state_val", rs1_val, 32'hDEAD);
    chk("s2_state_tag", {28'd0, rs1_tag}, 0);
    tick();

    // A stale commit writes the value and keeps the younger tag.
    rename_valid = 1; rename_rd_idx = 4; rename_tag = 1; rs1_idx = 4;
    eval(); tick();
    rename_tag = 5;
    eval(); tick(); idle();
    cdb_active = 1; cdb_tag = 1; cdb_rd_idx = 4; cdb_val = 7;
    eval(); chk("s3_no_bypass_tag", {28'd0, rs1_tag}, 5); tick(); idle();
    eval();
    chk("s3_val", rs1_val, 7);
    chk("s3_tag", {28'd0, rs1_tag}, 5);
    tick();

    // A commit and a rename on the same rd in one cycle.
    rename_valid = 1; rename_rd_idx = 6; rename_tag = 3; rs1_idx = 6;
    eval(); tick();
    rename_tag = 4; cdb_active = 1; cdb_tag = 3; cdb_rd_idx = 6; cdb_val = 9;
    eval(); tick(); idle();
    eval();
    chk("s4_val", rs1_val, 9);
    chk("s4_tag", {28'd0, rs1_tag}, 4);
    tick();

    // Mispredict flush with a same-cycle commit and a rename that must be dropped.
    rename_valid = 1; rename_rd_idx = 1; rename_tag = 6; eval(); tick();
    rename_rd_idx = 2; rename_tag = 7; eval(); tick();
    rename_rd_idx = 7; rename_tag = 8; eval(); tick(); idle();
    predict_fail = 1; cdb_active = 1; cdb_tag = 6; cdb_rd_idx = 1; cdb_val = 32'h11;
    rename_valid = 1; rename_rd_idx = 9; rename_tag = 3;
    eval(); tick(); idle();
    rs1_idx = 1; rs2_idx = 9;
    eval();
    chk("s5_val1", rs1_val, 32'h11);
    chk("s5_tag1", {28'd0, rs1_tag}, 0);
    chk("s5_tag9", {28'd0, rs2_tag}, 0);
    tick();
    rs1_idx = 7; rs2_idx = 2;
    eval();
    chk("s5_tag7", {28'd0, rs1_tag}, 0);
    chk("s5_tag2", {28'd0, rs2_tag}, 0);
    tick();

    // Hold while rdy_in is low; all writes to x0 are ignored.
    rdy_in = 0; rename_valid = 1; rename_rd_idx = 5; rename_tag = 9;
    cdb_active = 1; cdb_tag = 0; cdb_rd_idx = 5; cdb_val = 32'h55; rs1_idx = 5;
    eval(); tick(); idle();
    eval();
    chk("s6_hold_val", rs1_val, 0);
    chk("s6_hold_tag", {28'd0, rs1_tag}, 0);
    tick();
    rename_valid = 1; rename_rd_idx = 0; rename_tag = 3;
    cdb_active = 1; cdb_tag = 0; cdb_rd_idx = 0; cdb_val = 32'h99;
    rs1_idx = 0; rs2_idx = 0;
    eval(); tick(); idle();
    eval();
    chk("s6_x0_val", rs1_val, 0);
    chk("s6_x0_tag", {28'd0, rs1_tag}, 0);
    tick();

    // Random traffic, biased toward a few registers so that tags collide often.
    for (int n = 0; n < 400; n++) begin
      rst_in        = ($urandom_range(0, 199) == 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      predict_fail  = ($urandom_range(0, 19) == 0);
      rename_valid  = ($urandom_range(0, 1) == 1);
      rename_rd_idx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rename_tag    = 4'($urandom_range(1, 15));
      cdb_active    = ($urandom_range(0, 1) == 1);
      cdb_rd_idx    = 5'($urandom_range(0, 7));
      cdb_tag       = ($urandom_range(0, 3) != 0) ? m_tag[cdb_rd_idx] : 4'($urandom_range(0, 15));
      cdb_val       = $urandom;
      rs1_idx       = ($urandom_range(0, 1) == 1) ? cdb_rd_idx : 5'($urandom_range(0, 7));
      rs2_idx       = 5'($urandom_range(0, 31));
      eval();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
